// File: rtl/toggle_sequencer.sv
// Multi-channel toggle generator: each channel flips its output every period+1
// clocks, either free-running or for a burst of a programmed number of toggles.
module toggle_sequencer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CW-1:0]       load_channel,
  input  logic [WIDTH-1:0]    load_period,
  input  logic [WIDTH-1:0]    load_count,
  input  logic                load_mode,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] toggle_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1'b1);

  state_t             state_r       [CHANNELS];
  state_t             state_nxt_s   [CHANNELS];
  logic [WIDTH-1:0]   period_r      [CHANNELS];
  logic [WIDTH-1:0]   period_nxt_s  [CHANNELS];
  logic [WIDTH-1:0]   count_r       [CHANNELS];
  logic [WIDTH-1:0]   count_nxt_s   [CHANNELS];
  logic [WIDTH-1:0]   tick_r        [CHANNELS];
  logic [WIDTH-1:0]   tick_nxt_s    [CHANNELS];
  logic [WIDTH-1:0]   remaining_r   [CHANNELS];
  logic [WIDTH-1:0]   remaining_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] mode_r;
  logic [CHANNELS-1:0] mode_nxt_s;
  logic [CHANNELS-1:0] toggle_r;
  logic [CHANNELS-1:0] toggle_nxt_s;
  logic [CHANNELS-1:0] busy_r;
  logic [CHANNELS-1:0] done_r;
  logic [CHANNELS-1:0] done_nxt_s;
  logic [CHANNELS-1:0] load_hit_s;
  logic                load_ready_s;
  logic                chan_in_range_s;

  // Load handshake decode; out-of-range channels always accept and are dropped.
  always_comb begin
    load_ready_s    = 1'b1;
    load_hit_s      = {CHANNELS{1'b0}};
    chan_in_range_s = ({1'b0, load_channel} < (CW + 1)'(CHANNELS));
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_in_range_s && (load_channel == CW'(i))) begin
        load_ready_s  = (state_r[i] == IDLE);
        load_hit_s[i] = load_valid && (state_r[i] == IDLE);
      end else begin
        load_hit_s[i] = 1'b0;
      end
    end
  end

  // Per-channel next-state, counter and output logic.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_nxt_s[i]     = state_r[i];
      period_nxt_s[i]    = period_r[i];
      count_nxt_s[i]     = count_r[i];
      mode_nxt_s[i]      = mode_r[i];
      tick_nxt_s[i]      = tick_r[i];
      remaining_nxt_s[i] = remaining_r[i];
      toggle_nxt_s[i]    = toggle_r[i];
      done_nxt_s[i]      = 1'b0;
      case (state_r[i])
        IDLE: begin
          if (load_hit_s[i]) begin
            // A same-edge start is deliberately dropped in favour of the load.
            period_nxt_s[i] = load_period;
            count_nxt_s[i]  = load_count;
            mode_nxt_s[i]   = load_mode;
          end else if (start[i] && !stop[i]) begin
            if (mode_r[i] && (count_r[i] == ZERO_W)) begin
              done_nxt_s[i] = 1'b1;
            end else begin
              state_nxt_s[i]     = RUN;
              tick_nxt_s[i]      = period_r[i];
              remaining_nxt_s[i] = count_r[i];
            end
          end else begin
            state_nxt_s[i] = IDLE;
          end
        end
        RUN: begin
          if (stop[i]) begin
            state_nxt_s[i] = IDLE;
          end else if (tick_r[i] == ZERO_W) begin
            toggle_nxt_s[i] = ~toggle_r[i];
            tick_nxt_s[i]   = period_r[i];
            if (mode_r[i]) begin
              remaining_nxt_s[i] = remaining_r[i] - ONE_W;
              if (remaining_r[i] == ONE_W) begin
                state_nxt_s[i] = IDLE;
                done_nxt_s[i]  = 1'b1;
              end else begin
                state_nxt_s[i] = RUN;
              end
            end else begin
              remaining_nxt_s[i] = remaining_r[i];
            end
          end else begin
            tick_nxt_s[i] = tick_r[i] - ONE_W;
          end
        end
        default: begin
          state_nxt_s[i] = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i]     <= IDLE;
        period_r[i]    <= ZERO_W;
        count_r[i]     <= ZERO_W;
        tick_r[i]      <= ZERO_W;
        remaining_r[i] <= ZERO_W;
      end
      mode_r   <= {CHANNELS{1'b0}};
      toggle_r <= {CHANNELS{1'b0}};
      busy_r   <= {CHANNELS{1'b0}};
      done_r   <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i]     <= state_nxt_s[i];
        period_r[i]    <= period_nxt_s[i];
        count_r[i]     <= count_nxt_s[i];
        tick_r[i]      <= tick_nxt_s[i];
        remaining_r[i] <= remaining_nxt_s[i];
        busy_r[i]      <= (state_nxt_s[i] == RUN);
      end
      mode_r   <= mode_nxt_s;
      toggle_r <= toggle_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign load_ready = load_ready_s;
  assign toggle_out = toggle_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: doc/toggle_sequencer.md
# toggle_sequencer

Parametrised multi-channel toggle generator. Each channel holds a programmed period and toggle count, and on `start` drives its `toggle_out` bit with a flip every `period+1` clocks. A channel runs either free-running or as a burst of exactly `count` toggles. It generalises the single-bit fixed toggle loop into configurable, stoppable, handshaked channels, and is the standard source of test waveforms and strobes in the Circuit Maker 2 flow.

## Interface
- `CHANNELS`, default 4: number of independent channels, minimum 1.
- `WIDTH`, default 8: width of the period and count registers.
- `CW`, default `max(1, $clog2(CHANNELS))`: channel index width (derived localparam).

- `clock`: input, 1 bit. Single clock; all state updates on its posedge.
- `reset_n`: input, 1 bit. Synchronous, active-low reset.
- `load_valid`: input, 1 bit. Configuration write request.
- `load_ready`: output, 1 bit. High when the addressed channel accepts configuration.
- `load_channel`: input, CW bits. Target channel of the write.
- `load_period`: input, WIDTH bits. Flip interval minus 1.
- `load_count`: input, WIDTH bits. Number of toggles in burst mode.
- `load_mode`: input, 1 bit. 0 = free-run, 1 = burst.
- `start`: input, CHANNELS bits. Per-channel start request, level sampled each edge.
- `stop`: input, CHANNELS bits. Per-channel abort request.
- `toggle_out`: output, CHANNELS bits. Registered toggle outputs.
- `busy`: output, CHANNELS bits. High while the channel is in RUN.
- `done`: output, CHANNELS bits. One-cycle pulse when a burst completes.

## Operation
- Per-channel state: config (`period`, `count`, `mode`), FSM {IDLE, RUN}, down-counter `tick` (WIDTH bits), down-counter `remaining` (WIDTH bits).
- **Reset** (`reset_n`=0 at an edge), for all channels:
  - FSM=IDLE, `toggle_out`=0, `busy`=0, `done`=0.
  - `period`=0, `count`=0, `mode`=0, `tick`=0, `remaining`=0.
  - Reset overrides every other input, including mid-run and mid-load.
- **Load handshake**:
  - `load_ready` = (`load_channel` ≥ CHANNELS) OR (addressed channel in IDLE). It is combinational from `load_channel` and state.
  - A transfer occurs on an edge with `load_valid` && `load_ready`. The config registers of that channel take the payload.
  - A transfer to an out-of-range channel completes and is discarded.
  - While the addressed channel is in RUN, `load_ready`=0. The master must hold `load_valid` and the payload stable until the transfer.
- **IDLE → RUN**: on an edge with `start[i]`=1, `stop[i]`=0, and no accepted load to channel i that cycle.
  - `tick` ← `period`, `remaining` ← `count`.
  - Exception: burst mode with `count`=0. The channel stays IDLE, `toggle_out` is unchanged, and `done[i]` pulses.
- **RUN**, each edge:
  - If `tick`=0: flip `toggle_out[i]` and set `tick` ← `period`. In burst mode also decrement `remaining`.
  - Otherwise: `tick` ← `tick`−1.
- **Burst completion**: the edge that performs the flip while `remaining`=1 sets the FSM to IDLE and `done[i]`=1 for exactly the next cycle.
- **Free-run**: runs until stopped. `remaining` is ignored.
- **RUN → IDLE on stop**: on any edge with `stop[i]`=1. No flip happens on that edge, no `done` pulse is generated, and `toggle_out` holds its value.
- **Simultaneous events**:
  - `stop` wins over `start` and over a flip due that edge.
  - `start` while in RUN is ignored; there is no restart.
  - A load and a `start` to the same IDLE channel on the same edge: the load is taken and the start is ignored.
- `toggle_out` is never cleared except by reset. A new run continues from the current level.
- Channels are fully independent. Loads to channel i never disturb channel j.

## Timing
- `busy[i]` = (FSM==RUN), registered. It rises the cycle after the start edge and falls the cycle after the completion or stop edge.
- First flip occurs on edge t+1+`period`, where t is the start edge. Subsequent flips occur every `period`+1 edges.
- `period`=0 gives a flip every clock (toggle_out = clock/2).
- A burst of N toggles occupies N·(`period`+1) cycles of RUN. `done` is asserted in the cycle after the final flip edge, coincident with `busy` falling.
- Back-to-back: `start` may be held high. A channel restarts on the first edge it is IDLE, which gives one IDLE cycle between bursts.
- Latency from an accepted load to a usable start is 1 edge.

## Test plan
- Reset: drive `reset_n`=0 for 2 edges with `start`=all ones. Required: `toggle_out`=0, `busy`=0, `done`=0, `load_ready`=1.
- Free-run: load ch0 with period=2, mode=0, then pulse `start[0]` at edge t. Required: `toggle_out[0]` flips at edges t+3, t+6, t+9. Then `stop[0]` at t+10 → `busy[0]`=0 from t+11 and the level holds.
- Burst: load ch1 with period=0, count=5, mode=1, then start. Required: 5 consecutive flips so that `toggle_out[1]` ends at 1, `busy[1]` is high for 5 cycles, and `done[1]` is high for exactly 1 cycle.
- Edge configs: burst with count=0 → `done` pulses, no flip, `busy` stays 0. Then period=255, count=1 → a single flip 256 edges after start.
- Handshake: while ch2 runs, hold `load_valid` to ch2 → `load_ready`=0 and the config is unchanged until completion, then accepted. A concurrent load to ch3 (IDLE) is accepted immediately.
- Conflicts: same-edge `start` and `stop` → stays IDLE. Same-edge load and `start` to ch0 → config updated, no run. Reset mid-burst → all outputs 0 on the next cycle.
